// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule: streams W0..W(NUM_ROUNDS-1) for one 512-bit block from a 16-word sliding window.
// Define SHA256_MSG_SCHED_BYTESWAP_EN to byte-reverse each input word on load (little-endian hosts).
module sha256_msg_schedule #(
  parameter int NUM_ROUNDS = 64
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clear_i,
  input  logic         block_valid_i,
  output logic         block_ready_o,
  input  logic [511:0] block_i,
  output logic         w_valid_o,
  input  logic         w_ready_i,
  output logic [31:0]  w_data_o,
  output logic [5:0]   w_idx_o,
  output logic         w_last_o,
  output logic         busy_o
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [5:0] LAST = 6'(NUM_ROUNDS - 1);
  state_t      state;
  logic [5:0]  t;
  logic [31:0] win [16];
  logic [31:0] w_new;
  function automatic logic [31:0] ld(input logic [31:0] x);
`ifdef SHA256_MSG_SCHED_BYTESWAP_EN
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
    return x;
`endif
  endfunction
  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
  endfunction
  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction
  assign w_new = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      t     <= '0;
      for (int k = 0; k < 16; k++) win[k] <= '0;
    end else if (clear_i) begin
      state <= IDLE;
      t     <= '0;
    end else if (state == IDLE) begin
      if (block_valid_i) begin
        state <= RUN;
        t     <= '0;
        for (int k = 0; k < 16; k++) win[k] <= ld(block_i[511-32*k -: 32]);
      end
    end else if (w_ready_i) begin
      for (int k = 0; k < 15; k++) win[k] <= win[k+1];
      win[15] <= w_new;
      t       <= (t == LAST) ? 6'd0 : t + 6'd1;
      state   <= (t == LAST) ? IDLE : RUN;
    end
  end
  assign block_ready_o = state == IDLE;
  assign w_valid_o     = state == RUN;
  assign busy_o        = state == RUN;
  assign w_data_o      = win[0];
  assign w_idx_o       = t;
  assign w_last_o      = state == RUN && t == LAST;
endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb_sha256_msg_schedule: directed checks of the SHA-256 schedule against a reference word list.
module tb_sha256_msg_schedule;
  logic         CLK = 0;
  logic         RST = 0;
  logic         clear_i = 0;
  logic         block_valid_i = 0;
  logic         block_ready_o;
  logic [511:0] block_i = '0;
  logic         w_valid_o;
  logic         w_ready_i = 0;
  logic [31:0]  w_data_o;
  logic [5:0]   w_idx_o;
  logic         w_last_o;
  logic         busy_o;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_w [64];
  logic [511:0] abc_raw, blk2_raw, rep_raw;
  bit stopped;

  sha256_msg_schedule #(.NUM_ROUNDS(64)) dut (
    .CLK(CLK), .RST(RST), .clear_i(clear_i), .block_valid_i(block_valid_i),
    .block_ready_o(block_ready_o), .block_i(block_i), .w_valid_o(w_valid_o),
    .w_ready_i(w_ready_i), .w_data_o(w_data_o), .w_idx_o(w_idx_o),
    .w_last_o(w_last_o), .busy_o(busy_o)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] s0(input logic [31:0] x);
    return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] s1(input logic [31:0] x);
    return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
  endfunction
  function automatic logic [31:0] host(input logic [31:0] x);
`ifdef SHA256_MSG_SCHED_BYTESWAP_EN
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
    return x;
`endif
  endfunction

  // Expected words come from the textbook recurrence over the logical (post-load) block.
  task automatic build(input logic [511:0] raw);
    for (int i = 0; i < 16; i++) exp_w[i] = host(raw[511-32*i -: 32]);
    for (int i = 16; i < 64; i++)
      exp_w[i] = s1(exp_w[i-2]) + exp_w[i-7] + s0(exp_w[i-15]) + exp_w[i-16];
  endtask

  task automatic load(input logic [511:0] raw, input bit hold);
    build(raw);
    block_i = raw;
    block_valid_i = 1;
    @(negedge CLK);
    block_valid_i = hold;
  endtask

  task automatic consume(input int pct, input int stop, input bit hand, output bit st);
    int cnt = 0;
    bit stall = 0;
    logic [31:0] pd = '0;
    logic [5:0] pi = '0;
    st = 0;
    for (int c = 0; c < 3000; c++) begin
      chk("w_valid", {31'b0, w_valid_o}, 1);
      chk("busy", {31'b0, busy_o}, 1);
      chk("block_ready", {31'b0, block_ready_o}, 0);
      chk("w_data", w_data_o, exp_w[cnt]);
      chk("w_idx", {26'b0, w_idx_o}, cnt);
      chk("w_last", {31'b0, w_last_o}, {31'b0, cnt == 63});
      if (stall) begin
        chk("stall_data", w_data_o, pd);
        chk("stall_idx", {26'b0, w_idx_o}, {26'b0, pi});
      end
      if (hand && cnt == 16) chk("abc_w16", w_data_o, 32'h61626380);
      if (hand && cnt == 17) chk("abc_w17", w_data_o, 32'h000f0000);
      if (stop >= 0 && cnt == stop) begin
        st = 1;
        w_ready_i = 0;
        return;
      end
      w_ready_i = ($urandom_range(99) < pct);
      stall = !w_ready_i;
      pd = w_data_o;
      pi = w_idx_o;
      @(negedge CLK);
      if (w_ready_i) cnt++;
      if (cnt == 64) begin
        w_ready_i = 0;
        return;
      end
    end
    chk("done_count", cnt, 64);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, {31'b0, w_valid_o}, 0);
    chk({tag, "_busy"}, {31'b0, busy_o}, 0);
    chk({tag, "_ready"}, {31'b0, block_ready_o}, 1);
    chk({tag, "_last"}, {31'b0, w_last_o}, 0);
    chk({tag, "_idx"}, {26'b0, w_idx_o}, 0);
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin
      abc_raw[511-32*k -: 32]  = host(k == 0 ? 32'h61626380 : k == 15 ? 32'h00000018 : 32'h0);
      blk2_raw[511-32*k -: 32] = 32'hdeadbeef ^ (32'h01010101 * k);
      rep_raw[511-32*k -: 32]  = 32'h01020304;
    end
    #3;
    chk_idle("reset");
    chk("reset_data", w_data_o, 0);
    @(negedge CLK);
    RST = 1;
    @(negedge CLK);
    chk_idle("post_reset");

    // abc block, consumer always ready
    load(abc_raw, 0);
    consume(100, -1, 1, stopped);
    chk_idle("abc_done");

    // abc block under 30% ready backpressure
    load(abc_raw, 0);
    consume(30, -1, 1, stopped);
    chk_idle("bp_done");

    // back-to-back: valid held high, block_i changed after first acceptance
    load(abc_raw, 1);
    block_i = blk2_raw;
    consume(100, -1, 1, stopped);
    chk_idle("gap");
    build(blk2_raw);
    @(negedge CLK);
    block_valid_i = 0;
    consume(100, -1, 0, stopped);

    // synchronous abort at index 20, with valid also high
    @(negedge CLK);
    load(abc_raw, 0);
    consume(100, 20, 1, stopped);
    chk("clear_stopped", {31'b0, stopped}, 1);
    clear_i = 1;
    w_ready_i = 1;
    block_valid_i = 1;
    @(negedge CLK);
    clear_i = 0;
    w_ready_i = 0;
    block_valid_i = 0;
    chk_idle("clear");
    load(blk2_raw, 0);
    consume(100, -1, 0, stopped);

    // asynchronous reset at index 40
    @(negedge CLK);
    load(abc_raw, 0);
    consume(100, 40, 1, stopped);
    chk("rst_stopped", {31'b0, stopped}, 1);
    #2 RST = 0;
    #1;
    chk_idle("async_rst");
    chk("async_rst_data", w_data_o, 0);
    @(negedge CLK);
    RST = 1;
    @(negedge CLK);
    load(abc_raw, 0);
    consume(100, -1, 1, stopped);

    // replicated 0x01020304 block: shows whether words are byte-reversed on load
    @(negedge CLK);
    load(rep_raw, 0);
`ifdef SHA256_MSG_SCHED_BYTESWAP_EN
    chk("rep_w0", w_data_o, 32'h04030201);
`else
    chk("rep_w0", w_data_o, 32'h01020304);
`endif
    consume(100, -1, 0, stopped);
    chk_idle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
